// File: rtl/speck_xor_sched.sv
// speck_xor_sched: iterative SPECK32/64 encryption controller.
// Every XOR of the data path and key schedule goes through one shared,
// external, combinational 16-bit XOR unit (xor_a/xor_b -> xor_y); modular
// adds and rotates are done locally. One XOR step per clock, four per round.
// Optional feature macro: SPECK_KEY_CACHE_EN (round-key cache + key_reuse).
module speck_xor_sched #(
  parameter int ROUNDS = 22,
  parameter int ALPHA  = 7,
  parameter int BETA   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pt_x,
  input  logic [15:0] pt_y,
  input  logic [63:0] key,
`ifdef SPECK_KEY_CACHE_EN
  input  logic        key_reuse,
`endif
  output logic [15:0] xor_a,
  output logic [15:0] xor_b,
  input  logic [15:0] xor_y,
  output logic        busy,
  output logic        done,
  output logic [15:0] ct_x,
  output logic [15:0] ct_y
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] x, y, k, l0, l1, l2, lnew;
  logic [4:0]  rnd;
  logic [1:0]  ph;
  logic [15:0] k_cur;
  logic        reuse_run;
  logic        round_end;
  logic        last_step;

  function automatic logic [15:0] ror_a(input logic [15:0] v);
    return (v >> ALPHA) | (v << (16 - ALPHA));
  endfunction

  function automatic logic [15:0] rol_b(input logic [15:0] v);
    return (v << BETA) | (v >> (16 - BETA));
  endfunction

`ifdef SPECK_KEY_CACHE_EN
  logic        cache_valid;
  logic [15:0] rk [ROUNDS];

  // Cache bookkeeping: choose reuse mode at accept, validate after a full run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reuse_run   <= 1'b0;
      cache_valid <= 1'b0;
    end else if (state == IDLE && start) begin
      reuse_run <= key_reuse && cache_valid;
    end else if (state == DONE && !reuse_run) begin
      cache_valid <= 1'b1;
    end
  end

  // Round-key file: capture the k used in ph0 of each round of a full run.
  always_ff @(posedge clk) begin
    if (state == RUN && ph == 2'd0 && !reuse_run) rk[rnd] <= k;
  end

  assign k_cur = reuse_run ? rk[rnd] : k;
`else
  assign reuse_run = 1'b0;
  assign k_cur     = k;
`endif

  // A reuse run skips the key-schedule phases, so its rounds end at ph1.
  assign round_end = reuse_run ? (ph == 2'd1) : (ph == 2'd3);
  assign last_step = round_end && (rnd == 5'(ROUNDS - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and shared-XOR operands, driven from registered state only.
  always_comb begin
    state_nxt = state;
    xor_a     = 16'h0000;
    xor_b     = 16'h0000;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        case (ph)
          2'd0: begin
            xor_a = ror_a(x) + y;
            xor_b = k_cur;
          end
          2'd1: begin
            xor_a = rol_b(y);
            xor_b = x;
          end
          2'd2: begin
            xor_a = k + ror_a(l0);
            xor_b = {11'b0, rnd};
          end
          default: begin
            xor_a = rol_b(k);
            xor_b = lnew;
          end
        endcase
        if (last_step) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Cipher state, key schedule, counters and ciphertext capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= 16'h0000;
      y    <= 16'h0000;
      k    <= 16'h0000;
      l0   <= 16'h0000;
      l1   <= 16'h0000;
      l2   <= 16'h0000;
      lnew <= 16'h0000;
      rnd  <= 5'd0;
      ph   <= 2'd0;
      ct_x <= 16'h0000;
      ct_y <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x   <= pt_x;
            y   <= pt_y;
            k   <= key[15:0];
            l0  <= key[31:16];
            l1  <= key[47:32];
            l2  <= key[63:48];
            rnd <= 5'd0;
            ph  <= 2'd0;
          end
        end
        RUN: begin
          case (ph)
            2'd0: x <= xor_y;
            2'd1: y <= xor_y;
            2'd2: lnew <= xor_y;
            default: begin
              k  <= xor_y;
              l0 <= l1;
              l1 <= l2;
              l2 <= lnew;
            end
          endcase
          if (round_end) begin
            ph  <= 2'd0;
            rnd <= rnd + 5'd1;
          end else begin
            ph <= ph + 2'd1;
          end
          // In a reuse run the final step is ph1, so y is still being written.
          if (last_step) begin
            ct_x <= x;
            ct_y <= reuse_run ? xor_y : y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_speck_xor_sched.sv
// Scoreboard bench for speck_xor_sched: a plain SPECK32/64 reference model
// produces the expected shared-XOR operand trace and ciphertext per run; a
// negedge monitor pops and compares them as the DUT presents them.
module tb_speck_xor_sched;
  localparam int ROUNDS = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pt_x = 16'h0;
  logic [15:0] pt_y = 16'h0;
  logic [63:0] key = 64'h0;
`ifdef SPECK_KEY_CACHE_EN
  logic        key_reuse = 1'b0;
`endif
  logic [15:0] xor_a, xor_b, xor_y, ct_x, ct_y;
  logic        busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] cx;
    logic [15:0] cy;
    int          lat;
  } exp_t;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } tr_t;

  exp_t        exp_q[$];
  tr_t         tr_q[$];
  exp_t        e_cur;
  tr_t         t_cur;
  logic [15:0] rk_m [ROUNDS];
  bit          cache_valid_m = 1'b0;
  int          bcnt = 0;
  bit          done_prev = 1'b0;

  speck_xor_sched dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .pt_x  (pt_x),
    .pt_y  (pt_y),
    .key   (key),
`ifdef SPECK_KEY_CACHE_EN
    .key_reuse (key_reuse),
`endif
    .xor_a (xor_a),
    .xor_b (xor_b),
    .xor_y (xor_y),
    .busy  (busy),
    .done  (done),
    .ct_x  (ct_x),
    .ct_y  (ct_y)
  );

  always #5 clk = ~clk;

  // The shared XOR unit.
  assign xor_y = xor_a ^ xor_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] ror7(input logic [15:0] v);
    return {v[6:0], v[15:7]};
  endfunction

  function automatic logic [15:0] rol2(input logic [15:0] v);
    return {v[13:0], v[15:14]};
  endfunction

  // Reference SPECK32/64: records every XOR operand pair and the result.
  task automatic model(input logic [15:0] px, input logic [15:0] py,
                       input logic [63:0] kk, input bit reuse);
    logic [15:0] x, y, k, a, b;
    logic [15:0] l [ROUNDS + 3];
    tr_t  t;
    exp_t e;
    x = px; y = py; k = kk[15:0];
    l[0] = kk[31:16]; l[1] = kk[47:32]; l[2] = kk[63:48];
    for (int i = 0; i < ROUNDS; i++) begin
      if (reuse) k = rk_m[i];
      else       rk_m[i] = k;
      a = ror7(x) + y; b = k; x = a ^ b;
      t.a = a; t.b = b; tr_q.push_back(t);
      a = rol2(y); b = x; y = a ^ b;
      t.a = a; t.b = b; tr_q.push_back(t);
      if (!reuse) begin
        a = k + ror7(l[i]); b = 16'(i); l[i + 3] = a ^ b;
        t.a = a; t.b = b; tr_q.push_back(t);
        a = rol2(k); b = l[i + 3]; k = a ^ b;
        t.a = a; t.b = b; tr_q.push_back(t);
      end
    end
    e.cx = x; e.cy = y; e.lat = reuse ? 2 * ROUNDS + 1 : 4 * ROUNDS + 1;
    exp_q.push_back(e);
    if (!reuse) cache_valid_m = 1'b1;
  endtask

  // Monitor: operand trace every cycle, ciphertext and busy length at done.
  always @(negedge clk) begin
    if (rst) begin
      bcnt      = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) bcnt++;
      else      bcnt = 0;
      if (busy && !done) begin
        if (tr_q.size() == 0) begin
          check("trace_underflow", 32'(tr_q.size()), 32'd1);
        end else begin
          t_cur = tr_q.pop_front();
          check("xor_a_run", {16'h0, xor_a}, {16'h0, t_cur.a});
          check("xor_b_run", {16'h0, xor_b}, {16'h0, t_cur.b});
        end
      end else begin
        check("xor_a_idle", {16'h0, xor_a}, 32'h0);
        check("xor_b_idle", {16'h0, xor_b}, 32'h0);
      end
      if (done) begin
        check("done_one_cycle", {31'h0, done_prev}, 32'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(exp_q.size()), 32'd1);
        end else begin
          e_cur = exp_q.pop_front();
          check("ct_x", {16'h0, ct_x}, {16'h0, e_cur.cx});
          check("ct_y", {16'h0, ct_y}, {16'h0, e_cur.cy});
          check("busy_cycles", 32'(bcnt), 32'(e_cur.lat));
        end
      end
      done_prev = done;
    end
  end

  // Issue one start pulse from IDLE; inputs are scrambled after the accept edge.
  task automatic issue(input logic [15:0] px, input logic [15:0] py,
                       input logic [63:0] kk, input bit reuse_req);
    bit r;
    r = reuse_req && cache_valid_m;
    model(px, py, kk, r);
    @(posedge clk); #1;
    pt_x = px; pt_y = py; key = kk; start = 1'b1;
`ifdef SPECK_KEY_CACHE_EN
    key_reuse = reuse_req;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    pt_x = 16'($urandom); pt_y = 16'($urandom); key = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_time", {31'h0, busy}, 32'h0);
    check("run_consumed", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    check("done_in_time", {31'h0, done}, 32'h1);
  endtask

  task automatic check_known();
    check("kv_ct_x", {16'h0, ct_x}, 32'hA868);
    check("kv_ct_y", {16'h0, ct_y}, 32'h42F2);
  endtask

  task automatic apply_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_xor_a", {16'h0, xor_a}, 32'h0);
    check("rst_xor_b", {16'h0, xor_b}, 32'h0);
    check("rst_ct_x", {16'h0, ct_x}, 32'h0);
    check("rst_ct_y", {16'h0, ct_y}, 32'h0);
    exp_q.delete();
    tr_q.delete();
    cache_valid_m = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
  endtask

  localparam logic [63:0] KV_KEY = 64'h1918_1110_0908_0100;

  initial begin
    logic [15:0] px, py;
    logic [63:0] kk;

    // Reset defaults.
    apply_reset();
    repeat (5) @(negedge clk);
    check("idle_busy", {31'h0, busy}, 32'h0);
    check("idle_done", {31'h0, done}, 32'h0);

    // Known vector, then ciphertext hold.
    issue(16'h6574, 16'h694C, KV_KEY, 1'b0);
    wait_idle(200);
    check_known();
    repeat (10) @(negedge clk);
    check_known();

    // Start pulsed mid-run with different data must be ignored.
    issue(16'h6574, 16'h694C, KV_KEY, 1'b0);
    repeat (28) @(posedge clk);
    #1; pt_x = 16'h1234; pt_y = 16'hBEEF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_idle(200);
    check_known();

    // Reset mid-run: no done, then a fresh start works.
    issue(16'($urandom), 16'($urandom), {$urandom, $urandom}, 1'b0);
    repeat (38) @(posedge clk);
    apply_reset();
    repeat (100) @(negedge clk);
    check("no_run_after_rst", {31'h0, busy}, 32'h0);
    issue(16'h6574, 16'h694C, KV_KEY, 1'b0);
    wait_idle(200);
    check_known();

    // Randomized runs, the second of each pair started back-to-back from DONE.
    for (int i = 0; i < 3; i++) begin
      issue(16'($urandom), 16'($urandom), {$urandom, $urandom}, 1'b0);
      wait_done(200);
      px = 16'($urandom); py = 16'($urandom); kk = {$urandom, $urandom};
      model(px, py, kk, 1'b0);
      pt_x = px; pt_y = py; key = kk; start = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      start = 1'b0;
      check("b2b_accepted", {31'h0, busy}, 32'h1);
      wait_idle(200);
    end

`ifdef SPECK_KEY_CACHE_EN
    // Cached round keys: full run fills the cache, reuse run ignores key.
    issue(16'h6574, 16'h694C, KV_KEY, 1'b0);
    wait_idle(200);
    check_known();
    issue(16'h6574, 16'h694C, 64'h0, 1'b1);
    wait_idle(200);
    check_known();
    // After reset the cache is invalid: key_reuse falls back to a full run.
    apply_reset();
    issue(16'h6574, 16'h694C, KV_KEY, 1'b1);
    wait_idle(200);
    check_known();
    key_reuse = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1, "watchdog");
  end

endmodule
